// File: rtl/mc_control_if.sv
// Control-unit <-> datapath bundle: IR fields and ALU flag in, mux selects and strobes out.
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       iord;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output alu_ctl, alu_src_a, alu_src_b, imm_zext, pc_src, pc_en, iord, ir_write,
           mem_write, reg_write, reg_dst, mem_to_reg, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  alu_ctl, alu_src_a, alu_src_b, imm_zext, pc_src, pc_en, iord, ir_write,
           mem_write, reg_write, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-lite control FSM (Moore, except pc_en in BRANCH which follows zero).
module mc_control (
  input  logic            clk,
  input  logic            rst,
  mc_control_if.master    ctl_if
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2, StMemRd = 4'd3,
    StMemWb  = 4'd4,  StMemWr  = 4'd5,  StRtEx   = 4'd6, StRtWb  = 4'd7,
    StBranch = 4'd8,  StImmEx  = 4'd9,  StImmWb  = 4'd10, StJump = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluXor = 4'd4;

  state_e     r_state, w_next;
  logic       w_rt_legal;
  logic [3:0] w_rt_alu;

  logic [3:0] w_alu_ctl;
  logic       w_alu_src_a, w_imm_zext, w_pc_en, w_iord, w_ir_write, w_mem_write;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_rt_legal = 1'b1;
    w_rt_alu   = AluAdd;
    case (ctl_if.funct)
      6'b100000: w_rt_alu = AluAdd;
      6'b100010: w_rt_alu = AluSub;
      6'b100100: w_rt_alu = AluAnd;
      6'b100101: w_rt_alu = AluOr;
      6'b100110: w_rt_alu = AluXor;
      default:   w_rt_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = StFetch;
    w_alu_ctl    = AluAdd;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_imm_zext   = 1'b0;
    w_pc_src     = 2'b00;
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_illegal    = 1'b0;

    unique case (r_state)
      StFetch: begin
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
        w_pc_en     = 1'b1;
        w_next      = StDecode;
      end
      StDecode: begin
        w_alu_src_b = 2'b11;
        case (ctl_if.op)
          OpLw, OpSw:            w_next = StMemAdr;
          OpBeq, OpBne:          w_next = StBranch;
          OpAddi, OpAndi, OpOri: w_next = StImmEx;
          OpJ:                   w_next = StJump;
          OpRtype: begin
            if (w_rt_legal) w_next = StRtEx;
            else            w_illegal = 1'b1;
          end
          default:               w_illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (ctl_if.op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        w_iord = 1'b1;
        w_next = StMemWb;
      end
      StMemWb: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      StMemWr: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      StRtEx: begin
        w_alu_src_a = 1'b1;
        w_alu_ctl   = w_rt_alu;
        w_next      = StRtWb;
      end
      StRtWb: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      StBranch: begin
        w_alu_src_a = 1'b1;
        w_alu_ctl   = AluSub;
        w_pc_src    = 2'b01;
        // Combinational on zero so the branch resolves in this same cycle.
        w_pc_en     = (ctl_if.op == OpBne) ? ~ctl_if.zero : ctl_if.zero;
      end
      StImmEx: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_imm_zext  = (ctl_if.op == OpAndi) || (ctl_if.op == OpOri);
        if (ctl_if.op == OpAndi)     w_alu_ctl = AluAnd;
        else if (ctl_if.op == OpOri) w_alu_ctl = AluOr;
        w_next      = StImmWb;
      end
      StImmWb: begin
        w_reg_write = 1'b1;
      end
      StJump: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
      end
      default: w_next = StFetch;
    endcase

    // Reset holds every output low, even though the state register already reads FETCH.
    if (rst) begin
      w_alu_ctl    = AluAdd;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_imm_zext   = 1'b0;
      w_pc_src     = 2'b00;
      w_pc_en      = 1'b0;
      w_iord       = 1'b0;
      w_ir_write   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_illegal    = 1'b0;
    end
  end

  assign ctl_if.alu_ctl    = w_alu_ctl;
  assign ctl_if.alu_src_a  = w_alu_src_a;
  assign ctl_if.alu_src_b  = w_alu_src_b;
  assign ctl_if.imm_zext   = w_imm_zext;
  assign ctl_if.pc_src     = w_pc_src;
  assign ctl_if.pc_en      = w_pc_en;
  assign ctl_if.iord       = w_iord;
  assign ctl_if.ir_write   = w_ir_write;
  assign ctl_if.mem_write  = w_mem_write;
  assign ctl_if.reg_write  = w_reg_write;
  assign ctl_if.reg_dst    = w_reg_dst;
  assign ctl_if.mem_to_reg = w_mem_to_reg;
  assign ctl_if.illegal    = w_illegal;
  assign ctl_if.state      = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction expected traces built from the instruction tables.
module tb_mc_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_if (bus)
  );

  // {alu_ctl, src_a, src_b, zext, pc_src, pc_en, iord, ir_write, mem_write, reg_write,
  //  reg_dst, mem_to_reg, illegal}
  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] outs;
  } rec_t;

  logic [17:0] w_outs;
  assign w_outs = {bus.alu_ctl, bus.alu_src_a, bus.alu_src_b, bus.imm_zext, bus.pc_src,
                   bus.pc_en, bus.iord, bus.ir_write, bus.mem_write, bus.reg_write,
                   bus.reg_dst, bus.mem_to_reg, bus.illegal};

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  logic tog_q[$];

  function automatic rec_t r(input logic [3:0] st, input logic [3:0] alu, input logic a,
                             input logic [1:0] b, input logic z, input logic [1:0] pcs,
                             input logic pcen, input logic iord, input logic irw,
                             input logic mw, input logic rw, input logic rd,
                             input logic mtr, input logic ill);
    return {st, alu, a, b, z, pcs, pcen, iord, irw, mw, rw, rd, mtr, ill};
  endfunction

  function automatic int rt_alu(input logic [5:0] f);
    case (f)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h26: return 4;
      default: return -1;
    endcase
  endfunction

  // Expected per-cycle trace of one instruction, FETCH first, ending before the next FETCH.
  task automatic build(input logic [5:0] op, input logic [5:0] f, input logic z);
    logic ill;
    ill = 1'b0;
    exp_q.delete();
    exp_q.push_back(r(0, 0, 0, 2'b01, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0));
    case (op)
      6'h23: begin
        exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(2, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(3, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      end
      6'h2B: begin
        exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(2, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(5, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      end
      6'h04, 6'h05: begin
        exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(8, 1, 1, 2'b00, 0, 2'b01, (op == 6'h05) ? ~z : z,
                          0, 0, 0, 0, 0, 0, 0));
      end
      6'h08, 6'h0C, 6'h0D: begin
        exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(9, (op == 6'h08) ? 4'd0 : (op == 6'h0C) ? 4'd2 : 4'd3, 1, 2'b10,
                          op != 6'h08, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
      6'h02: begin
        exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(r(11, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      6'h00: begin
        if (rt_alu(f) >= 0) begin
          exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          exp_q.push_back(r(6, 4'(rt_alu(f)), 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          exp_q.push_back(r(7, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) exp_q.push_back(r(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // Called in the low clock phase with the DUT in FETCH; returns the same way.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
    bus.op = op;
    bus.funct = f;
    bus.zero = z;
    build(op, f, z);
    obs_q.delete();
    tog_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      obs_q.push_back({bus.state, w_outs});
      if (bus.state == 4'd8) begin
        bus.zero = ~z;
        #1;
        tog_q.push_back(bus.pc_en);
        bus.zero = z;
      end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.op = 6'h23;
    bus.funct = 6'h3F;
    bus.zero = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.state !== 4'd0 || w_outs !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_hold: state=%0d outs=%h, want state=0 outs=0", bus.state, w_outs);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.state !== 4'd0 || bus.ir_write !== 1'b1 || bus.pc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d ir_write=%b pc_en=%b, want 0 1 1",
               bus.state, bus.ir_write, bus.pc_en);
    end
  endtask

  task automatic test_lw;
    logic [3:0] seq[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_instr(6'h23, 6'h00, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].st !== seq[i]) begin
        n_fail++;
        $display("FAIL lw cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (bus.state !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_return: state=%0d, want 0", bus.state);
    end
  endtask

  task automatic test_rtype_xor;
    run_instr(6'h00, 6'h26, 1'b0);
    n_tests++;
    if (obs_q.size() != 4 || obs_q[2].st !== 4'd6 || obs_q[2].outs[17:14] !== 4'd4) begin
      n_fail++;
      $display("FAIL xor_rtex: got %h, want state 6 alu_ctl 4", obs_q[2]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL xor cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (bus.state !== 4'd0) begin
      n_fail++;
      $display("FAIL xor_return: state=%0d, want 0", bus.state);
    end
  endtask

  task automatic test_branch;
    logic [5:0] ops[3] = '{6'h04, 6'h05, 6'h05};
    logic       zs[3]  = '{1'b1, 1'b1, 1'b0};
    logic       pe[3]  = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      run_instr(ops[k], 6'h00, zs[k]);
      n_tests++;
      if (obs_q[2].st !== 4'd8 || obs_q[2].outs[7] !== pe[k] ||
          obs_q[2].outs[9:8] !== 2'b01) begin
        n_fail++;
        $display("FAIL branch%0d: got %h, want state 8 pc_en %b pc_src 01",
                 k, obs_q[2], pe[k]);
      end
      n_tests++;
      if (tog_q.size() != 1 || tog_q[0] !== ~pe[k]) begin
        n_fail++;
        $display("FAIL branch%0d_comb: toggled pc_en samples=%0d, want one of %b",
                 k, tog_q.size(), ~pe[k]);
      end
      n_tests++;
      if (bus.state !== 4'd0) begin
        n_fail++;
        $display("FAIL branch%0d_return: state=%0d, want 0", k, bus.state);
      end
    end
  endtask

  task automatic test_ori;
    run_instr(6'h0D, 6'h15, 1'b0);
    n_tests++;
    if (obs_q[2].st !== 4'd9 || obs_q[2].outs[17:14] !== 4'd3 || obs_q[2].outs[10] !== 1'b1 ||
        obs_q[3].st !== 4'd10 || obs_q[3].outs[3:2] !== 2'b10) begin
      n_fail++;
      $display("FAIL ori: got %h %h, want IMMEX alu 3 zext 1 then IMMWB rw 1 rd 0",
               obs_q[2], obs_q[3]);
    end
    n_tests++;
    if (bus.state !== 4'd0) begin
      n_fail++;
      $display("FAIL ori_return: state=%0d, want 0", bus.state);
    end
  endtask

  task automatic test_illegal;
    logic [5:0] ops[2] = '{6'h3F, 6'h00};
    int         n_ill;
    for (int k = 0; k < 2; k++) begin
      run_instr(ops[k], 6'h00, 1'b0);
      n_ill = 0;
      foreach (obs_q[i]) n_ill += int'(obs_q[i].outs[0]);
      n_tests++;
      if (obs_q.size() != 2 || obs_q[1] !== exp_q[1] || n_ill != 1 || bus.state !== 4'd0) begin
        n_fail++;
        $display("FAIL illegal%0d: got %h illegal_cycles=%0d end_state=%0d, want %h 1 0",
                 k, obs_q[1], n_ill, bus.state, exp_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_memwr;
    bus.op = 6'h2B;
    bus.funct = 6'h00;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    n_tests++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL memwr_reach: state=%0d mem_write=%b, want 5 1", bus.state, bus.mem_write);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.state !== 4'd0 || w_outs !== 18'd0) begin
      n_fail++;
      $display("FAIL memwr_async_rst: state=%0d outs=%h, want 0 0", bus.state, w_outs);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.state !== 4'd0 || w_outs !== 18'd0) begin
      n_fail++;
      $display("FAIL memwr_rst_hold: state=%0d outs=%h, want 0 0", bus.state, w_outs);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'h2B, 6'h00, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sw_after_rst cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [5:0] legal_op[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D};
    logic [5:0] legal_fn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    logic [5:0] op, fn;
    logic       z;
    for (int n = 0; n < 150; n++) begin
      int unsigned k;
      k  = $urandom_range(0, 10);
      op = (k < 8) ? legal_op[k] : (k == 8) ? 6'h02 : 6'($urandom);
      fn = ($urandom_range(0, 4) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      z  = 1'($urandom);
      run_instr(op, fn, z);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d op=%h fn=%h cyc%0d: got %h, want %h",
                   n, op, fn, i, obs_q[i], exp_q[i]);
        end
      end
      n_tests++;
      if (bus.state !== 4'd0) begin
        n_fail++;
        $display("FAIL rand%0d_return op=%h fn=%h: state=%0d, want 0", n, op, fn, bus.state);
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_rtype_xor;
    test_branch;
    test_ori;
    test_illegal;
    test_reset_mid_memwr;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
